// File: rtl/mig_tg_pkg.sv
// Shared types, command encodings and per-lane pattern function for the
// MIG UI write-then-readback traffic generator.
package mig_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RD_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_INCR  = 2'd0,
    PAT_ADDR  = 2'd1,
    PAT_INV   = 2'd2,
    PAT_INCR3 = 2'd3
  } pattern_e;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // One 32-bit lane of a beat; addr is the beat address already zero-extended
  // and offset, i is the beat index, j the lane index. All arithmetic wraps mod 2^32.
  function automatic logic [31:0] lane_word(input pattern_e mode, input logic [31:0] seed,
                                            input logic [31:0] addr, input logic [31:0] i,
                                            input logic [31:0] j);
    case (mode)
      PAT_ADDR: lane_word = addr;
      PAT_INV:  lane_word = ~(seed + i + j);
      default:  lane_word = seed + i + j;
    endcase
  endfunction

endpackage

// File: rtl/mig_app_traffic_gen_if.sv
// MIG 7-series user-interface (app_*) bundle; the traffic generator is the
// master, the memory controller the slave.
interface mig_app_traffic_gen_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 29
);
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_rdy;
  logic                app_wdf_rdy;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/mig_tg_pattern.sv
// Combinational beat generator: builds a full DATA_W word for beat idx from
// the latched run settings. Used for both write data and expected read data.
module mig_tg_pattern
  import mig_tg_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 29,
  parameter int ADDR_STEP = 8,
  parameter int BEATS_W   = 10
) (
  input  pattern_e           mode,
  input  logic [31:0]        seed,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [BEATS_W-1:0] idx,
  output logic [DATA_W-1:0]  word
);
  localparam int LANES = DATA_W / 32;

  logic [31:0] beat_addr;

  assign beat_addr = 32'(base_addr) + 32'(idx) * 32'(ADDR_STEP);

  // Fill every 32-bit lane from the shared lane function.
  always_comb begin
    word = '0;
    for (int j = 0; j < LANES; j++) begin
      word[j*32 +: 32] = lane_word(mode, seed, beat_addr, 32'(idx), 32'(j));
    end
  end
endmodule

// File: rtl/mig_app_traffic_gen.sv
// Write-then-readback traffic generator and checker for the MIG UI port.
// Writes num_beats patterned beats from base_addr, reads them back in order,
// counts mismatches and flags a stalled read stream.
module mig_app_traffic_gen
  import mig_tg_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 29,
  parameter int ADDR_STEP = 8,
  parameter int BEATS_W   = 10,
  parameter int TIMEOUT   = 4096
) (
  input  logic                  ui_clk,
  input  logic                  sys_rst,
  input  logic                  init_calib_complete,
  input  logic                  start,
  input  logic [BEATS_W-1:0]    num_beats,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [1:0]            pattern_mode,
  input  logic [31:0]           seed,
  mig_app_traffic_gen_if.master app,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [BEATS_W-1:0]    first_err_beat
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [BEATS_W-1:0] nb_q, wr_idx_q, rd_cmd_idx_q, rd_idx_q;
  logic [BEATS_W-1:0] last_idx, rd_idx_next;
  logic [ADDR_W-1:0]  base_q, addr_q;
  pattern_e           mode_q;
  logic [31:0]        seed_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               timeout_q;
  logic [15:0]        err_q;
  logic [BEATS_W-1:0] first_q;
  logic [DATA_W-1:0]  wr_word, exp_word;
  logic               accept, xfer, rd_check, rd_mismatch, idle_expire;

  mig_tg_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP), .BEATS_W(BEATS_W))
    u_wr_pattern (.mode(mode_q), .seed(seed_q), .base_addr(base_q), .idx(wr_idx_q), .word(wr_word));

  mig_tg_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP), .BEATS_W(BEATS_W))
    u_rd_pattern (.mode(mode_q), .seed(seed_q), .base_addr(base_q), .idx(rd_idx_q), .word(exp_word));

  assign accept      = start & init_calib_complete & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign xfer        = app.app_rdy & app.app_wdf_rdy;
  assign last_idx    = nb_q - BEATS_W'(1);
  assign rd_check    = app.app_rd_data_valid & ((state_q == ST_READ) | (state_q == ST_RD_WAIT));
  assign rd_mismatch = rd_check & (app.app_rd_data != exp_word);
  assign rd_idx_next = rd_idx_q + BEATS_W'(rd_check);
  assign idle_expire = (state_q == ST_RD_WAIT) & ~rd_check & (idle_q == IDLE_W'(TIMEOUT - 1));

  assign app.app_addr     = addr_q;
  assign app.app_wdf_end  = app.app_wdf_wren;
  assign app.app_wdf_mask = '0;

  assign busy           = (state_q == ST_WRITE) | (state_q == ST_READ) | (state_q == ST_RD_WAIT);
  assign done           = (state_q == ST_DONE);
  assign error          = done & ((err_q != 16'h0000) | timeout_q);
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_beat = first_q;

  // State register; reset aborts any run in progress.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and UI command outputs; write command and data are gated together.
  always_comb begin
    state_d          = state_q;
    app.app_en       = 1'b0;
    app.app_cmd      = CMD_WRITE;
    app.app_wdf_wren = 1'b0;
    app.app_wdf_data = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = (num_beats == '0) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        app.app_en       = xfer;
        app.app_wdf_wren = xfer;
        app.app_wdf_data = wr_word;
        if (xfer && (wr_idx_q == last_idx)) state_d = ST_READ;
      end
      ST_READ: begin
        app.app_cmd = CMD_READ;
        app.app_en  = 1'b1;
        if (app.app_rdy && (rd_cmd_idx_q == last_idx)) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if ((rd_idx_next == nb_q) || idle_expire) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run settings, beat counters, address walker and read-check results.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      nb_q         <= '0;
      base_q       <= '0;
      addr_q       <= '0;
      mode_q       <= PAT_INCR;
      seed_q       <= '0;
      wr_idx_q     <= '0;
      rd_cmd_idx_q <= '0;
      rd_idx_q     <= '0;
      idle_q       <= '0;
      timeout_q    <= 1'b0;
      err_q        <= '0;
      first_q      <= '0;
    end else if (accept) begin
      nb_q         <= num_beats;
      base_q       <= base_addr;
      addr_q       <= base_addr;
      mode_q       <= pattern_e'(pattern_mode);
      seed_q       <= seed;
      wr_idx_q     <= '0;
      rd_cmd_idx_q <= '0;
      rd_idx_q     <= '0;
      idle_q       <= '0;
      timeout_q    <= 1'b0;
      err_q        <= '0;
      first_q      <= '0;
    end else begin
      case (state_q)
        ST_WRITE: begin
          if (xfer) begin
            wr_idx_q <= wr_idx_q + BEATS_W'(1);
            if (wr_idx_q == last_idx) addr_q <= base_q;
            else                      addr_q <= addr_q + ADDR_W'(ADDR_STEP);
          end
        end
        ST_READ: begin
          if (app.app_rdy) begin
            rd_cmd_idx_q <= rd_cmd_idx_q + BEATS_W'(1);
            addr_q       <= addr_q + ADDR_W'(ADDR_STEP);
          end
        end
        default: ;
      endcase
      if (rd_check) begin
        rd_idx_q <= rd_idx_q + BEATS_W'(1);
        if (rd_mismatch) begin
          if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
          if (err_q == 16'h0000) first_q <= rd_idx_q;
        end
      end
      if ((state_q == ST_RD_WAIT) && !rd_check) idle_q <= idle_q + IDLE_W'(1);
      else                                      idle_q <= '0;
      if (idle_expire) timeout_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mig_app_traffic_gen.sv
// Scoreboard bench for mig_app_traffic_gen: a behavioural MIG model answers
// commands, expected commands and run results are queued when a run is started,
// and a monitor pops and compares them as the DUT presents them.
module tb_mig_app_traffic_gen;

  localparam logic [2:0] C_WR = 3'b000;
  localparam logic [2:0] C_RD = 3'b001;

  typedef struct {
    logic [2:0]   cmd;
    logic [28:0]  addr;
    logic [255:0] data;
  } exp_t;

  typedef struct {
    logic [15:0] err;
    logic [9:0]  first;
    logic        error;
    logic        timeout;
  } result_t;

  typedef struct {
    logic [255:0] data;
    int           due;
    int           beat;
  } pend_t;

  logic        ui_clk;
  logic        sys_rst;
  logic        init_calib_complete;
  logic        start;
  logic [9:0]  num_beats;
  logic [28:0] base_addr;
  logic [1:0]  pattern_mode;
  logic [31:0] seed;
  logic        busy, done, error, timeout;
  logic [15:0] err_count;
  logic [9:0]  first_err_beat;

  mig_app_traffic_gen_if #(.DATA_W(256), .ADDR_W(29)) app ();

  mig_app_traffic_gen #(.DATA_W(256), .ADDR_W(29), .ADDR_STEP(8), .BEATS_W(10), .TIMEOUT(4096)) dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .start(start), .num_beats(num_beats), .base_addr(base_addr),
    .pattern_mode(pattern_mode), .seed(seed), .app(app.master),
    .busy(busy), .done(done), .error(error), .timeout(timeout),
    .err_count(err_count), .first_err_beat(first_err_beat)
  );

  int checks = 0;
  int errors = 0;
  int runs_done = 0;
  int cyc = 0;

  exp_t    exp_q[$];
  result_t res_q[$];
  pend_t   rd_pend[$];
  logic [255:0] mem [logic [28:0]];

  int rdy_toggle = 0;
  int stall_beat = -1;
  int stall_left = 0;
  int corrupt_a = -1;
  int corrupt_b = -1;
  int drop_last = 0;
  int run_n = 0;
  int wr_seen = 0;
  int rd_seen = 0;

  exp_t    me;
  result_t mr;
  pend_t   mp;
  logic    done_prev = 1'b0;

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] expData(input logic [1:0] mode, input logic [31:0] sd,
                                           input logic [28:0] base, input int i);
    logic [31:0] a;
    logic [31:0] lane;
    a = {3'b000, base} + 32'(i) * 32'd8;
    expData = '0;
    for (int j = 0; j < 8; j++) begin
      case (mode)
        2'd1:    lane = a;
        2'd2:    lane = ~(sd + 32'(i) + 32'(j));
        default: lane = sd + 32'(i) + 32'(j);
      endcase
      expData[j*32 +: 32] = lane;
    end
  endfunction

  // Queue the expected write/read commands and result, then pulse start.
  task automatic applyStimulus(input int n, input logic [28:0] base, input logic [1:0] mode,
                               input logic [31:0] sd, input result_t res);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cmd = C_WR; e.addr = base + 29'(i * 8); e.data = expData(mode, sd, base, i);
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e.cmd = C_RD; e.addr = base + 29'(i * 8); e.data = '0;
      exp_q.push_back(e);
    end
    res_q.push_back(res);
    run_n = n; wr_seen = 0; rd_seen = 0; stall_left = 0;
    @(posedge ui_clk); #1;
    num_beats = 10'(n); base_addr = base; pattern_mode = mode; seed = sd; start = 1'b1;
    @(posedge ui_clk); #1;
    start = 1'b0;
  endtask

  task automatic waitRun(input int target, input int budget);
    int k;
    k = 0;
    while (runs_done < target && k < budget) begin
      @(posedge ui_clk);
      k++;
    end
    checkOutput("run_completes", 256'(runs_done >= target), 256'(1));
    @(posedge ui_clk); #1;
    checkOutput("all_cmds_issued", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic runTest(input int n, input logic [28:0] base, input logic [1:0] mode,
                         input logic [31:0] sd, input result_t res, input int budget);
    int target;
    target = runs_done + 1;
    applyStimulus(n, base, mode, sd, res);
    waitRun(target, budget);
  endtask

  // Behavioural MIG: drive ready/read data just after the edge, capture transfers mid-cycle.
  initial begin : mig_model
    app.app_rdy = 1'b1; app.app_wdf_rdy = 1'b1;
    app.app_rd_data_valid = 1'b0; app.app_rd_data = '0;
    forever begin
      @(posedge ui_clk); #1;
      cyc++;
      app.app_rd_data_valid = 1'b0;
      app.app_rd_data = '0;
      if (!sys_rst) begin
        rd_pend.delete();
        app.app_rdy = 1'b1;
        app.app_wdf_rdy = 1'b1;
      end else begin
        app.app_rdy = (rdy_toggle != 0) ? cyc[0] : 1'b1;
        if (stall_left > 0) begin
          app.app_wdf_rdy = 1'b0;
          stall_left--;
        end else begin
          app.app_wdf_rdy = 1'b1;
        end
        if (rd_pend.size() > 0 && rd_pend[0].due <= cyc) begin
          mp = rd_pend.pop_front();
          if (!(drop_last != 0 && mp.beat == run_n - 1)) begin
            app.app_rd_data_valid = 1'b1;
            app.app_rd_data = (mp.beat == corrupt_a || mp.beat == corrupt_b) ? (mp.data ^ 256'd1) : mp.data;
          end
        end
      end
      @(negedge ui_clk);
      if (sys_rst && app.app_en && app.app_rdy) begin
        if (app.app_cmd == C_WR && app.app_wdf_wren) begin
          mem[app.app_addr] = app.app_wdf_data;
          wr_seen++;
          if (wr_seen == stall_beat) stall_left = 3;
        end else if (app.app_cmd == C_RD) begin
          mp.data = mem.exists(app.app_addr) ? mem[app.app_addr] : '0;
          mp.due  = cyc + 3;
          mp.beat = rd_seen;
          rd_pend.push_back(mp);
          rd_seen++;
        end
      end
    end
  end

  // Monitor: compare every accepted command and every run result against the queues.
  initial begin : monitor
    forever begin
      @(negedge ui_clk);
      if (!sys_rst) begin
        done_prev = 1'b0;
      end else begin
        if (app.app_en && app.app_cmd == C_WR)
          checkOutput("wr_en_gated", 256'(app.app_en), 256'(app.app_rdy & app.app_wdf_rdy));
        if (app.app_en && app.app_rdy) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_cmd", 256'(app.app_en), 256'(0));
          end else begin
            me = exp_q.pop_front();
            checkOutput("cmd", 256'(app.app_cmd), 256'(me.cmd));
            checkOutput("addr", 256'(app.app_addr), 256'(me.addr));
            if (me.cmd == C_WR) begin
              checkOutput("wdata", app.app_wdf_data, me.data);
              checkOutput("wren", 256'(app.app_wdf_wren), 256'(1));
              checkOutput("wdf_end", 256'(app.app_wdf_end), 256'(1));
              checkOutput("wdf_mask", 256'(app.app_wdf_mask), 256'(0));
            end
          end
        end
        if (done && !done_prev) begin
          if (res_q.size() == 0) begin
            checkOutput("unexpected_done", 256'(done), 256'(0));
          end else begin
            mr = res_q.pop_front();
            checkOutput("err_count", 256'(err_count), 256'(mr.err));
            checkOutput("first_err_beat", 256'(first_err_beat), 256'(mr.first));
            checkOutput("error", 256'(error), 256'(mr.error));
            checkOutput("timeout", 256'(timeout), 256'(mr.timeout));
            checkOutput("busy_at_done", 256'(busy), 256'(0));
          end
          runs_done++;
        end
        done_prev = done;
      end
    end
  end

  initial begin : stimulus
    result_t clean, r;
    int target;
    clean = '{err: 16'd0, first: 10'd0, error: 1'b0, timeout: 1'b0};
    sys_rst = 1'b0; init_calib_complete = 1'b0; start = 1'b0;
    num_beats = '0; base_addr = '0; pattern_mode = '0; seed = '0;
    repeat (3) @(posedge ui_clk); #1;
    checkOutput("rst_app_en", 256'(app.app_en), 256'(0));
    checkOutput("rst_app_cmd", 256'(app.app_cmd), 256'(0));
    checkOutput("rst_app_addr", 256'(app.app_addr), 256'(0));
    checkOutput("rst_wdata", app.app_wdf_data, 256'(0));
    checkOutput("rst_flags", 256'({busy, done, error, timeout}), 256'(0));
    checkOutput("rst_err_count", 256'(err_count), 256'(0));
    sys_rst = 1'b1;

    $display("[TB] start while calibration low is ignored");
    @(posedge ui_clk); #1;
    num_beats = 10'd5; start = 1'b1;
    @(posedge ui_clk); #1;
    start = 1'b0;
    repeat (2) @(posedge ui_clk); #1;
    checkOutput("nocal_busy", 256'(busy), 256'(0));
    checkOutput("nocal_done", 256'(done), 256'(0));
    init_calib_complete = 1'b1;

    $display("[TB] zero-beat run");
    target = runs_done + 1;
    applyStimulus(0, 29'h100, 2'd0, 32'd0, clean);
    checkOutput("zero_done_next", 256'(done), 256'(1));
    checkOutput("zero_busy", 256'(busy), 256'(0));
    waitRun(target, 20);

    $display("[TB] 10 beats incr, ideal MIG, extra start while busy");
    target = runs_done + 1;
    applyStimulus(10, 29'h0, 2'd0, 32'd0, clean);
    repeat (3) @(posedge ui_clk); #1;
    checkOutput("busy_in_run", 256'(busy), 256'(1));
    num_beats = 10'd3; base_addr = 29'h500; start = 1'b1;
    @(posedge ui_clk); #1;
    start = 1'b0;
    waitRun(target, 200);

    $display("[TB] write fifo stall on beat 4, app_rdy toggling");
    rdy_toggle = 1; stall_beat = 4;
    runTest(12, 29'h100, 2'd2, 32'hDEADBEEF, clean, 400);
    rdy_toggle = 0; stall_beat = -1;

    $display("[TB] corrupted read beats 2 and 7");
    corrupt_a = 2; corrupt_b = 7;
    r = '{err: 16'd2, first: 10'd2, error: 1'b1, timeout: 1'b0};
    runTest(10, 29'h800, 2'd0, 32'd5, r, 200);
    corrupt_a = -1; corrupt_b = -1;

    $display("[TB] dropped last read beat");
    drop_last = 1;
    r = '{err: 16'd0, first: 10'd0, error: 1'b1, timeout: 1'b1};
    runTest(4, 29'h40, 2'd3, 32'd9, r, 6000);
    checkOutput("timeout_done", 256'(done), 256'(1));
    drop_last = 0;

    $display("[TB] reset mid-write, then address wrap");
    applyStimulus(8, 29'h40, 2'd0, 32'h1234, clean);
    repeat (3) @(posedge ui_clk);
    checkOutput("busy_before_rst", 256'(busy), 256'(1));
    #3 sys_rst = 1'b0;
    #1;
    checkOutput("arst_app_en", 256'({app.app_en, app.app_wdf_wren}), 256'(0));
    checkOutput("arst_app_addr", 256'(app.app_addr), 256'(0));
    checkOutput("arst_app_cmd", 256'(app.app_cmd), 256'(0));
    checkOutput("arst_wdata", app.app_wdf_data, 256'(0));
    checkOutput("arst_flags", 256'({busy, done, error, timeout}), 256'(0));
    checkOutput("arst_counts", 256'({err_count, first_err_beat}), 256'(0));
    exp_q.delete();
    res_q.delete();
    repeat (2) @(posedge ui_clk); #1;
    sys_rst = 1'b1;
    runTest(6, 29'h1FFFFFF0, 2'd1, 32'd0, clean, 200);

    repeat (5) @(posedge ui_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
